lepton_frame_sequencer: RTL and testbench

//  Sequences the Lepton VoSPI packet reader into whole 60-line frames. Issues one packet

---
 rtl/lepton_frame_sequencer_if.sv | 28 ++
 rtl/lepton_frame_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_lepton_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lepton_frame_sequencer_if.sv
// Packet-reader / frame-store handshake bundle for lepton_frame_sequencer.
// master = sequencer side, slave = reader/frame-store side.
interface lepton_frame_sequencer_if;
  logic        ENABLE;
  logic        PKT_START;
  logic        PKT_DONE;
  logic [15:0] PKT_ID;
  logic        PKT_CRC_OK;
  logic        CS_FORCE_HI;
  logic        LINE_VALID;
  logic [5:0]  LINE_NUM;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        RESYNC;
  logic [7:0]  ERR_COUNT;

  modport master (
    input  ENABLE, PKT_DONE, PKT_ID, PKT_CRC_OK,
    output PKT_START, CS_FORCE_HI, LINE_VALID, LINE_NUM,
           FRAME_START, FRAME_DONE, RESYNC, ERR_COUNT
  );

  modport slave (
    output ENABLE, PKT_DONE, PKT_ID, PKT_CRC_OK,
    input  PKT_START, CS_FORCE_HI, LINE_VALID, LINE_NUM,
           FRAME_START, FRAME_DONE, RESYNC, ERR_COUNT
  );
endinterface

// File: rtl/lepton_frame_sequencer.sv
// Lepton VoSPI frame sequencer: requests packets, classifies them, resyncs on errors.
// Define LEPTON_CRC_CHECK_EN to make a failed packet CRC force a resync.
module lepton_frame_sequencer #(
  parameter int unsigned LINES         = 60,
  parameter int unsigned RESYNC_CYCLES = 4625000,
  parameter int unsigned PKT_GAP       = 30,
  parameter int unsigned TIMEOUT       = 8192,
  parameter int unsigned MAX_DISCARDS  = 1024
) (
  input logic                         CLK_25,
  input logic                         RST_N,
  lepton_frame_sequencer_if.master    bus
);

  localparam int unsigned TMR_MAX0 = (RESYNC_CYCLES > TIMEOUT) ? RESYNC_CYCLES : TIMEOUT;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > PKT_GAP) ? TMR_MAX0 : PKT_GAP;
  localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned DISC_W   = (MAX_DISCARDS > 1) ? $clog2(MAX_DISCARDS) : 1;

  localparam logic [TMR_W-1:0]  RESYNC_LAST  = TMR_W'(RESYNC_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  GAP_LAST     = TMR_W'(PKT_GAP - 1);
  localparam logic [DISC_W-1:0] DISC_LAST    = DISC_W'(MAX_DISCARDS - 1);
  localparam logic [5:0]        LAST_LINE    = 6'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESYNC, S_REQ, S_WAIT, S_CHECK, S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [5:0]        exp_q, exp_d;
  logic [7:0]        err_q, err_d;
  logic [5:0]        line_q, line_d;
  logic              is_disc_q, is_disc_d;
  logic              crc_ok_q, crc_ok_d;
  logic [5:0]        line_num_q, line_num_d;
  logic              pkt_start_q, pkt_start_d;
  logic              line_valid_q, line_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              cs_force_hi_q, cs_force_hi_d;
  logic              resync_q, resync_d;
  logic              fail;
  logic              crc_bad;
  logic              id_unused;

  assign id_unused = ^{bus.PKT_ID[15:12], bus.PKT_ID[7:6]};

`ifdef LEPTON_CRC_CHECK_EN
  assign crc_bad = !crc_ok_q;
`else
  logic crc_unused;
  assign crc_unused = crc_ok_q;
  assign crc_bad    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    disc_d        = disc_q;
    exp_d         = exp_q;
    err_d         = err_q;
    line_d        = line_q;
    is_disc_d     = is_disc_q;
    crc_ok_d      = crc_ok_q;
    line_num_d    = line_num_q;
    pkt_start_d   = 1'b0;
    line_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = line_valid_q && (line_num_q == LAST_LINE);
    fail          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.ENABLE) begin
          state_d = S_RESYNC;
          tmr_d   = '0;
        end
      end
      S_RESYNC: begin
        disc_d = '0;
        exp_d  = '0;
        if (tmr_q == RESYNC_LAST) begin
          state_d = S_REQ;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_REQ: begin
        if (!bus.ENABLE) begin
          state_d = S_IDLE;
        end else begin
          pkt_start_d = 1'b1;
          state_d     = S_WAIT;
          tmr_d       = '0;
        end
      end
      S_WAIT: begin
        // A completion on the final timeout cycle still wins over the timeout.
        if (bus.PKT_DONE) begin
          line_d    = bus.PKT_ID[5:0];
          is_disc_d = (bus.PKT_ID[11:8] == 4'hF);
          crc_ok_d  = bus.PKT_CRC_OK;
          state_d   = S_CHECK;
        end else if (tmr_q == TIMEOUT_LAST) begin
          fail = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (crc_bad) begin
          fail = 1'b1;
        end else if (is_disc_q) begin
          if (disc_q == DISC_LAST) begin
            fail = 1'b1;
          end else begin
            disc_d  = disc_q + DISC_W'(1);
            state_d = S_GAP;
            tmr_d   = '0;
          end
        end else if ((line_q == exp_q) && ({1'b0, line_q} < 7'(LINES))) begin
          disc_d        = '0;
          line_valid_d  = 1'b1;
          line_num_d    = line_q;
          frame_start_d = (line_q == 6'd0);
          exp_d         = (line_q == LAST_LINE) ? 6'd0 : exp_q + 6'd1;
          state_d       = S_GAP;
          tmr_d         = '0;
        end else begin
          fail = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = S_REQ;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      state_d = S_RESYNC;
      tmr_d   = '0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    // Status outputs decode the next state so they line up with it once registered.
    cs_force_hi_d = (state_d == S_IDLE) || (state_d == S_RESYNC);
    resync_d      = (state_d == S_RESYNC);
  end

  always_ff @(posedge CLK_25) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      disc_q        <= '0;
      exp_q         <= '0;
      err_q         <= '0;
      line_q        <= '0;
      is_disc_q     <= 1'b0;
      crc_ok_q      <= 1'b0;
      line_num_q    <= '0;
      pkt_start_q   <= 1'b0;
      line_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      cs_force_hi_q <= 1'b1;
      resync_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      disc_q        <= disc_d;
      exp_q         <= exp_d;
      err_q         <= err_d;
      line_q        <= line_d;
      is_disc_q     <= is_disc_d;
      crc_ok_q      <= crc_ok_d;
      line_num_q    <= line_num_d;
      pkt_start_q   <= pkt_start_d;
      line_valid_q  <= line_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      cs_force_hi_q <= cs_force_hi_d;
      resync_q      <= resync_d;
    end
  end

  assign bus.PKT_START   = pkt_start_q;
  assign bus.CS_FORCE_HI = cs_force_hi_q;
  assign bus.LINE_VALID  = line_valid_q;
  assign bus.LINE_NUM    = line_num_q;
  assign bus.FRAME_START = frame_start_q;
  assign bus.FRAME_DONE  = frame_done_q;
  assign bus.RESYNC      = resync_q;
  assign bus.ERR_COUNT   = err_q;

endmodule

// File: tb/tb_lepton_frame_sequencer.sv
// Scoreboard bench for lepton_frame_sequencer with a packet-level reference model.
// Honours LEPTON_CRC_CHECK_EN the same way as the design.
module tb_lepton_frame_sequencer;

  localparam int NLINES = 60;
  localparam int RSYNC  = 100;
  localparam int GAP    = 4;
  localparam int TMO    = 50;
  localparam int MAXD   = 3;
`ifdef LEPTON_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef enum int {K_LINE, K_DISC, K_HOLD, K_RAND, K_RSTHOLD} kind_e;
  typedef struct {
    kind_e kind;
    int    line;
    bit    crc_ok;
  } resp_t;
  typedef struct {
    int line;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic RST_N;
  int   cyc = 0;

  lepton_frame_sequencer_if bus();

  lepton_frame_sequencer #(
    .LINES(NLINES), .RESYNC_CYCLES(RSYNC), .PKT_GAP(GAP),
    .TIMEOUT(TMO), .MAX_DISCARDS(MAXD)
  ) dut (
    .CLK_25(clk),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    passes = 0;
  resp_t plan[$];
  exp_t  exp_q[$];
  int    m_exp = 0;
  int    m_disc = 0;
  int    m_err = 0;
  int    frames_done = 0;
  bit    hold_hit = 1'b0;
  bit    late_go = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: one call per packet outcome, in packet order.
  task automatic model_error();
    m_err  = (m_err < 255) ? m_err + 1 : 255;
    m_exp  = 0;
    m_disc = 0;
  endtask

  task automatic model_packet(input bit disc, input int line, input bit crc_ok);
    exp_t e;
    if (CRC_EN && !crc_ok) model_error();
    else if (disc) begin
      m_disc++;
      if (m_disc >= MAXD) model_error();
    end else if (line == m_exp) begin
      e.line = line;
      e.cyc  = cyc;
      exp_q.push_back(e);
      m_disc = 0;
      m_exp  = (m_exp + 1) % NLINES;
    end else model_error();
  endtask

  function automatic logic [15:0] line_id(input int line);
    logic [3:0] nib;
    nib = 4'($urandom_range(0, 14));
    return {4'($urandom), nib, 2'($urandom), 6'(line)};
  endfunction

  // Packet reader model / stimulus driver.
  initial begin : reader
    resp_t r;
    int    start;
    int    d;
    int    rr;
    bit    disc;
    bus.PKT_DONE   = 1'b0;
    bus.PKT_ID     = '0;
    bus.PKT_CRC_OK = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.PKT_START && RST_N) begin
        start = cyc;
        if (plan.size() != 0) r = plan.pop_front();
        else begin
          r.kind = K_LINE; r.line = m_exp; r.crc_ok = 1'b1;
        end
        if (r.kind == K_RAND) begin
          rr = $urandom_range(0, 99);
          r.kind = K_LINE; r.line = m_exp; r.crc_ok = 1'b1;
          if (rr < 20) r.kind = K_DISC;
          else if (rr < 70) r.line = m_exp;
          else if (rr < 82) r.line = $urandom_range(0, 63);
          else if (rr < 88) r.crc_ok = 1'b0;
          else if (rr < 93) r.kind = K_HOLD;
        end
        if (r.kind == K_HOLD) begin
          model_error();
          for (int i = 0; i < 80 && !bus.RESYNC; i++) @(negedge clk);
          check("timeout_to_resync", cyc - start, TMO);
        end else if (r.kind == K_RSTHOLD) begin
          hold_hit = 1'b1;
          for (int i = 0; i < 50 && !late_go; i++) @(negedge clk);
          bus.PKT_DONE   = 1'b1;
          bus.PKT_ID     = line_id(0);
          bus.PKT_CRC_OK = 1'b1;
          @(negedge clk);
          bus.PKT_DONE   = 1'b0;
        end else begin
          d = $urandom_range(0, 4);
          repeat (d) @(negedge clk);
          disc = (r.kind == K_DISC);
          bus.PKT_DONE   = 1'b1;
          bus.PKT_ID     = disc ? {4'($urandom), 4'hF, 8'($urandom)} : line_id(r.line);
          bus.PKT_CRC_OK = r.crc_ok;
          model_packet(disc, r.line, r.crc_ok);
          @(negedge clk);
          bus.PKT_DONE   = 1'b0;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a line.
  initial begin : monitor
    exp_t e;
    int   run = 0;
    bit   fd_exp = 1'b0;
    bit   fd_next;
    forever begin
      @(negedge clk);
      fd_next = 1'b0;
      if (RST_N === 1'b1) begin
        if (bus.LINE_VALID) begin
          if (exp_q.size() == 0) check("unexpected_line_valid", bus.LINE_NUM, 99);
          else begin
            e = exp_q.pop_front();
            check("line_num", bus.LINE_NUM, e.line);
            check("frame_start", bus.FRAME_START, e.line == 0);
            check("done_to_line_latency", cyc - e.cyc, 2);
            fd_next = (e.line == NLINES - 1);
          end
        end else if (bus.FRAME_START) check("stray_frame_start", bus.FRAME_START, 0);
        if (bus.FRAME_DONE || fd_exp) begin
          check("frame_done", bus.FRAME_DONE, fd_exp);
          if (bus.FRAME_DONE) frames_done++;
        end
        if (bus.PKT_START) check("cs_low_at_pkt_start", bus.CS_FORCE_HI, 0);
        if (bus.RESYNC) run++;
        else if (run > 0) begin
          check("resync_length", run, RSYNC);
          run = 0;
        end
      end else run = 0;
      fd_exp = fd_next;
    end
  end

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && plan.size() != 0; i++) @(negedge clk);
    check(name, plan.size(), 0);
    repeat (300) @(negedge clk);
    check({name, "_err_count"}, bus.ERR_COUNT, m_err);
  endtask

  task automatic push(input kind_e k, input int line, input bit crc_ok);
    resp_t r;
    r.kind = k; r.line = line; r.crc_ok = crc_ok;
    plan.push_back(r);
  endtask

  initial begin : main
    int n;
    int bad;
    RST_N      = 1'b0;
    bus.ENABLE = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_force_hi", bus.CS_FORCE_HI, 1);
    check("rst_pkt_start", bus.PKT_START, 0);
    check("rst_line_valid", bus.LINE_VALID, 0);
    check("rst_frame_start", bus.FRAME_START, 0);
    check("rst_frame_done", bus.FRAME_DONE, 0);
    check("rst_resync", bus.RESYNC, 0);
    check("rst_line_num", bus.LINE_NUM, 0);
    check("rst_err_count", bus.ERR_COUNT, 0);
    RST_N = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_cs_hi_while_disabled", bus.CS_FORCE_HI, 1);

    bus.ENABLE = 1'b1;
    n = cyc;
    for (int i = 0; i < 300 && !bus.PKT_START; i++) @(negedge clk);
    check("enable_to_first_pkt_start", cyc - n, RSYNC + 2);

    n = frames_done + 1;
    for (int i = 0; i < 6000 && frames_done < n; i++) @(negedge clk);
    check("first_frame_done", frames_done, n);
    check("frame_err_count", bus.ERR_COUNT, m_err);

    push(K_DISC, 0, 1); push(K_DISC, 0, 1); push(K_LINE, 0, 1);
    push(K_DISC, 0, 1); push(K_DISC, 0, 1); push(K_DISC, 0, 1);
    drain("discards", 2000);

    for (int l = 0; l < 5; l++) push(K_LINE, l, 1);
    push(K_LINE, 7, 1);
    drain("out_of_order", 2000);

    push(K_HOLD, 0, 1);
    drain("timeout", 2000);

    push(K_LINE, 0, 0);
    drain("crc_fail_line0", 2000);

    for (int i = 0; i < 200; i++) push(K_RAND, 0, 1);
    drain("random", 30000);

    for (int i = 0; i < 300; i++) push(K_LINE, (i % 2) ? 63 : 7, 1);
    drain("saturate", 45000);
    check("scoreboard_empty", exp_q.size(), 0);

    push(K_RSTHOLD, 0, 1);
    for (int i = 0; i < 2000 && !hold_hit; i++) @(negedge clk);
    check("reached_wait_for_reset", hold_hit, 1);
    RST_N      = 1'b0;
    bus.ENABLE = 1'b0;
    @(negedge clk);
    check("wait_rst_cs_force_hi", bus.CS_FORCE_HI, 1);
    check("wait_rst_resync", bus.RESYNC, 0);
    check("wait_rst_pkt_start", bus.PKT_START, 0);
    check("wait_rst_line_valid", bus.LINE_VALID, 0);
    check("wait_rst_err_count", bus.ERR_COUNT, 0);
    check("wait_rst_line_num", bus.LINE_NUM, 0);
    RST_N   = 1'b1;
    late_go = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.LINE_VALID || bus.PKT_START || !bus.CS_FORCE_HI || bus.RESYNC) bad++;
    end
    check("late_done_ignored", bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
